// File: rtl/symbol_rank_sorter.sv
// ============================================================================
// Module   : symbol_rank_sorter
// Purpose  : Frame histogram of symbols 1..NSYM with saturating counters,
//            iterative selection sort by descending count, and a
//            valid/ready stream of the ranked (symbol, count) list.
// Revision : 1.0  initial parametrised release
// ============================================================================
`default_nettype none

module symbol_rank_sorter #(
    parameter int NSYM = 6,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int SW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_data,
    input  logic               in_last,
    output logic               cnt_valid,
    output logic [NSYM*CW-1:0] cnt_flat,
    output logic [CW-1:0]      ign_cnt,
    output logic               rank_valid,
    input  logic               rank_ready,
    output logic [SW-1:0]      rank_sym,
    output logic [CW-1:0]      rank_cnt,
    output logic               rank_last,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACC     = 3'd1,
        S_CNT_OUT = 3'd2,
        S_SORT    = 3'd3,
        S_EMIT    = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_cnt_valid;
    logic [CW-1:0]   r_cnt      [1:NSYM];
    logic [CW-1:0]   r_ign;
    logic [NSYM-1:0] r_sel;
    logic [SW-1:0]   r_pass;
    logic [SW-1:0]   r_step;
    logic            r_found;
    logic [SW-1:0]   r_best_sym;
    logic [CW-1:0]   r_best_cnt;
    logic [SW-1:0]   r_rank_sym [0:NSYM-1];
    logic [CW-1:0]   r_rank_cnt [0:NSYM-1];
    logic [SW-1:0]   r_emit_idx;

    logic            w_in_range;
    logic [SW-1:0]   w_sym;
    logic [SW-1:0]   w_scan_sym;
    logic [CW-1:0]   w_scan_cnt;
    logic            w_scan_sel;
    logic [SW-1:0]   w_emit_sym;
    logic [CW-1:0]   w_emit_cnt;

    // Upper data bits take part in the range test, so aliased values are ignored.
    assign w_in_range = (in_data != '0) && (in_data <= DW'(NSYM));
    assign w_sym      = in_data[SW-1:0];
    assign w_scan_sym = r_step + SW'(1);

    assign in_ready   = (r_state == S_IDLE) || (r_state == S_ACC);
    assign busy       = (r_state != S_IDLE);
    assign cnt_valid  = r_cnt_valid;
    assign ign_cnt    = r_ign;
    assign rank_valid = (r_state == S_EMIT);
    assign rank_sym   = rank_valid ? w_emit_sym : '0;
    assign rank_cnt   = rank_valid ? w_emit_cnt : '0;
    assign rank_last  = rank_valid && (r_emit_idx == SW'(NSYM - 1));

    for (genvar s = 1; s <= NSYM; s++) begin : g_flat
        assign cnt_flat[s*CW-1 -: CW] = r_cnt[s];
    end

    // Fetch the count and selected flag of the symbol visited by the current scan step.
    always_comb begin
        w_scan_cnt = '0;
        w_scan_sel = 1'b0;
        for (int s = 1; s <= NSYM; s++) begin
            if (w_scan_sym == SW'(s)) begin
                w_scan_cnt = r_cnt[s];
                w_scan_sel = r_sel[s-1];
            end
        end
    end

    // Select the ranked entry currently presented downstream.
    always_comb begin
        w_emit_sym = '0;
        w_emit_cnt = '0;
        for (int k = 0; k < NSYM; k++) begin
            if (r_emit_idx == SW'(k)) begin
                w_emit_sym = r_rank_sym[k];
                w_emit_cnt = r_rank_cnt[k];
            end
        end
    end

    // Control FSM with histogram, selection-sort and emit datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt_valid <= 1'b0;
            r_ign       <= '0;
            r_sel       <= '0;
            r_pass      <= '0;
            r_step      <= '0;
            r_found     <= 1'b0;
            r_best_sym  <= '0;
            r_best_cnt  <= '0;
            r_emit_idx  <= '0;
            for (int s = 1; s <= NSYM; s++) r_cnt[s] <= '0;
            for (int k = 0; k < NSYM; k++) begin
                r_rank_sym[k] <= '0;
                r_rank_cnt[k] <= '0;
            end
        end else begin
            r_cnt_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // First beat restarts the histogram and is counted itself.
                        for (int s = 1; s <= NSYM; s++)
                            r_cnt[s] <= (w_in_range && (w_sym == SW'(s))) ? CW'(1) : '0;
                        r_ign <= w_in_range ? '0 : CW'(1);
                        if (in_last) begin
                            r_state     <= S_CNT_OUT;
                            r_cnt_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        for (int s = 1; s <= NSYM; s++)
                            if (w_in_range && (w_sym == SW'(s)) && (r_cnt[s] != '1))
                                r_cnt[s] <= r_cnt[s] + CW'(1);
                        if (!w_in_range && (r_ign != '1))
                            r_ign <= r_ign + CW'(1);
                        if (in_last) begin
                            r_state     <= S_CNT_OUT;
                            r_cnt_valid <= 1'b1;
                        end
                    end
                end
                S_CNT_OUT: begin
                    r_state <= S_SORT;
                    r_sel   <= '0;
                    r_pass  <= '0;
                    r_step  <= '0;
                    r_found <= 1'b0;
                end
                S_SORT: begin
                    if (r_step == SW'(NSYM)) begin
                        // Commit cycle: store the pass winner and retire it from later scans.
                        for (int k = 0; k < NSYM; k++)
                            if (r_pass == SW'(k)) begin
                                r_rank_sym[k] <= r_best_sym;
                                r_rank_cnt[k] <= r_best_cnt;
                            end
                        for (int s = 1; s <= NSYM; s++)
                            if (r_best_sym == SW'(s)) r_sel[s-1] <= 1'b1;
                        r_found <= 1'b0;
                        r_step  <= '0;
                        if (r_pass == SW'(NSYM - 1)) begin
                            r_state    <= S_EMIT;
                            r_emit_idx <= '0;
                        end else begin
                            r_pass <= r_pass + SW'(1);
                        end
                    end else begin
                        // Strict greater-than keeps the lowest symbol on ties; the first
                        // unselected symbol always seeds the pass so zero counts still rank.
                        if (!w_scan_sel && (!r_found || (w_scan_cnt > r_best_cnt))) begin
                            r_best_sym <= w_scan_sym;
                            r_best_cnt <= w_scan_cnt;
                            r_found    <= 1'b1;
                        end
                        r_step <= r_step + SW'(1);
                    end
                end
                S_EMIT: begin
                    if (rank_ready) begin
                        if (r_emit_idx == SW'(NSYM - 1))
                            r_state <= S_IDLE;
                        else
                            r_emit_idx <= r_emit_idx + SW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_symbol_rank_sorter.sv
// ============================================================================
// Module   : tb_symbol_rank_sorter
// Purpose  : Scoreboard bench for symbol_rank_sorter (default and NSYM=10).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_symbol_rank_sorter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, rank_ready = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, cnt_valid, rank_valid, rank_last, busy;
    logic [47:0] cnt_flat;
    logic [7:0]  ign_cnt, rank_cnt;
    logic [3:0]  rank_sym;

    logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_rank_ready = 1'b0;
    logic [7:0]  b_in_data = 8'd0;
    logic        b_in_ready, b_cnt_valid, b_rank_valid, b_rank_last, b_busy;
    logic [39:0] b_cnt_flat;
    logic [3:0]  b_ign_cnt, b_rank_cnt;
    logic [3:0]  b_rank_sym;

    int n_cmp = 0;
    int n_err = 0;

    int frame_q[$];
    int exp_sym_q[$];
    int exp_cnt_q[$];
    int exp_cnt[16];
    int exp_ign;

    always #5 clk = ~clk;

    symbol_rank_sorter dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .cnt_valid(cnt_valid), .cnt_flat(cnt_flat), .ign_cnt(ign_cnt),
        .rank_valid(rank_valid), .rank_ready(rank_ready), .rank_sym(rank_sym),
        .rank_cnt(rank_cnt), .rank_last(rank_last), .busy(busy)
    );

    symbol_rank_sorter #(.NSYM(10), .DW(8), .CW(4), .SW(4)) dut10 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .cnt_valid(b_cnt_valid), .cnt_flat(b_cnt_flat), .ign_cnt(b_ign_cnt),
        .rank_valid(b_rank_valid), .rank_ready(b_rank_ready), .rank_sym(b_rank_sym),
        .rank_cnt(b_rank_cnt), .rank_last(b_rank_last), .busy(b_busy)
    );

    // Reference histogram with saturation; rank of a symbol = number of symbols
    // with a larger count, or an equal count and a smaller symbol number.
    task automatic model(input int nsym, input int cmax);
        int rk[16];
        exp_sym_q.delete();
        exp_cnt_q.delete();
        for (int s = 0; s < 16; s++) exp_cnt[s] = 0;
        exp_ign = 0;
        foreach (frame_q[i]) begin
            if (frame_q[i] >= 1 && frame_q[i] <= nsym) begin
                if (exp_cnt[frame_q[i]] < cmax) exp_cnt[frame_q[i]]++;
            end else if (exp_ign < cmax) begin
                exp_ign++;
            end
        end
        for (int s = 1; s <= nsym; s++) begin
            rk[s] = 0;
            for (int t = 1; t <= nsym; t++)
                if (exp_cnt[t] > exp_cnt[s] || (exp_cnt[t] == exp_cnt[s] && t < s)) rk[s]++;
        end
        for (int r = 0; r < nsym; r++)
            for (int s = 1; s <= nsym; s++)
                if (rk[s] == r) begin
                    exp_sym_q.push_back(s);
                    exp_cnt_q.push_back(exp_cnt[s]);
                end
    endtask

    function automatic logic [47:0] exp_flat6();
        logic [47:0] v = '0;
        for (int s = 1; s <= 6; s++) v[(s-1)*8 +: 8] = 8'(exp_cnt[s]);
        return v;
    endfunction

    // Drive frame_q into the default DUT; returns just after the in_last edge.
    task automatic send_frame();
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(frame_q[i]);
            in_last  = (i == frame_q.size() - 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Check the count publication and first-rank latency, optionally poking in_valid during the sort.
    task automatic check_counts(input string nm, input bit poke);
        int n;
        @(negedge clk);
        n_cmp++;
        if (cnt_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s cnt_out_state: cnt_valid=%b in_ready=%b busy=%b required 1,0,1", nm, cnt_valid, in_ready, busy);
        end
        n_cmp++;
        if (cnt_flat !== exp_flat6() || ign_cnt !== 8'(exp_ign)) begin
            n_err++;
            $display("FAIL %s counts: flat=%h ign=%0d required flat=%h ign=%0d", nm, cnt_flat, ign_cnt, exp_flat6(), exp_ign);
        end
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 8'd1;
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                n_cmp++;
                if (cnt_valid !== 1'b0 || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s cnt_pulse: cnt_valid=%b in_ready=%b required 0,0", nm, cnt_valid, in_ready);
                end
            end
        end while (!rank_valid && n < 300);
        in_valid = 1'b0;
        // rank_valid first appears in cycle k+2+NSYM*(NSYM+1), i.e. 43 edges after the in_last edge.
        n_cmp++;
        if (n != 43) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges required 43", nm, n);
        end
    endtask

    // Consume the ranked stream with a stall/toggle ready pattern and score each transfer.
    task automatic drain(input string nm, input int stall, input bit toggle);
        int cyc = 0, got = 0;
        bit rdy, held = 1'b0;
        logic [12:0] prev = '0, cur;
        while (got < 6 && cyc < 500) begin
            @(negedge clk);
            rdy = (cyc >= stall) && (!toggle || ((cyc - stall) % 2 == 0));
            rank_ready = rdy;
            cur = {rank_sym, rank_cnt, rank_last};
            n_cmp++;
            if (rank_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s emit_state: rank_valid=%b in_ready=%b required 1,0", nm, rank_valid, in_ready);
            end
            if (held) begin
                n_cmp++;
                if (cur !== prev) begin
                    n_err++;
                    $display("FAIL %s stall_stable: %h required %h", nm, cur, prev);
                end
            end
            if (rdy) begin
                n_cmp++;
                if (exp_sym_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_entry: sym=%0d with empty scoreboard", nm, rank_sym);
                end else begin
                    int es, ec;
                    es = exp_sym_q.pop_front();
                    ec = exp_cnt_q.pop_front();
                    if (rank_sym !== 4'(es) || rank_cnt !== 8'(ec) || rank_last !== (got == 5)) begin
                        n_err++;
                        $display("FAIL %s rank%0d: (%0d,%0d,last=%b) required (%0d,%0d,last=%b)",
                                 nm, got, rank_sym, rank_cnt, rank_last, es, ec, got == 5);
                    end
                end
                got++;
            end
            held = !rdy;
            prev = cur;
            cyc++;
        end
        @(negedge clk);
        rank_ready = 1'b0;
        n_cmp++;
        if (got != 6 || rank_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s emit_end: got=%0d rank_valid=%b busy=%b in_ready=%b required 6,0,0,1",
                     nm, got, rank_valid, busy, in_ready);
        end
        n_cmp++;
        if (cnt_flat !== exp_flat6() || ign_cnt !== 8'(exp_ign)) begin
            n_err++;
            $display("FAIL %s counts_hold: flat=%h ign=%0d required flat=%h ign=%0d", nm, cnt_flat, ign_cnt, exp_flat6(), exp_ign);
        end
    endtask

    task automatic run_frame(input string nm, input int stall, input bit toggle, input bit poke);
        model(6, 255);
        send_frame();
        check_counts(nm, poke);
        drain(nm, stall, toggle);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({cnt_valid, cnt_flat, ign_cnt, rank_valid, rank_sym, rank_cnt, rank_last, busy} !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: outputs=%h in_ready=%b required 0,1",
                     {cnt_valid, cnt_flat, ign_cnt, rank_valid, rank_sym, rank_cnt, rank_last, busy}, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        frame_q = '{1, 1, 2, 3, 3, 3, 6};
        run_frame("basic", 0, 1'b0, 1'b0);
    endtask

    task automatic test_tie();
        frame_q = '{5, 4, 5, 4};
        run_frame("tie", 0, 1'b0, 1'b1);
    endtask

    task automatic test_saturate();
        frame_q.delete();
        for (int i = 0; i < 300; i++) frame_q.push_back(2);
        frame_q.push_back(0);
        frame_q.push_back(7);
        frame_q.push_back(255);
        run_frame("saturate", 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        frame_q = '{6, 2, 2, 4, 4, 4, 1};
        run_frame("backpressure", 5, 1'b1, 1'b0);
    endtask

    task automatic test_all_ignored();
        frame_q = '{0, 9, 130};
        run_frame("all_ignored", 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        frame_q = '{1, 2, 3, 3};
        send_frame();
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({cnt_valid, cnt_flat, ign_cnt, rank_valid, rank_sym, rank_cnt, rank_last, busy} !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_reset: outputs=%h in_ready=%b required 0,1",
                     {cnt_valid, cnt_flat, ign_cnt, rank_valid, rank_sym, rank_cnt, rank_last, busy}, in_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        frame_q = '{6};
        run_frame("after_abort", 0, 1'b0, 1'b0);
    endtask

    task automatic test_nsym10();
        int n = 0, got = 0;
        frame_q.delete();
        for (int i = 0; i < 20; i++) frame_q.push_back(9);
        frame_q.push_back(10);
        model(10, 15);
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_data  = 8'(frame_q[i]);
            b_in_last  = (i == frame_q.size() - 1);
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b_cnt_valid !== 1'b1 || b_cnt_flat[32 +: 4] !== 4'd15 || b_cnt_flat[36 +: 4] !== 4'd1 || b_cnt_flat[31:0] !== '0) begin
            n_err++;
            $display("FAIL n10_counts: cnt_valid=%b flat=%h required 1, cnt9=15 cnt10=1 others 0", b_cnt_valid, b_cnt_flat);
        end
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!b_rank_valid && n < 400);
        // 110 sort cycles plus the CNT_OUT cycle.
        n_cmp++;
        if (n != 111) begin
            n_err++;
            $display("FAIL n10_latency: got %0d edges required 111", n);
        end
        while (got < 10 && n < 600) begin
            @(negedge clk);
            b_rank_ready = 1'b1;
            n++;
            if (b_rank_valid) begin
                int es, ec;
                es = exp_sym_q.pop_front();
                ec = exp_cnt_q.pop_front();
                n_cmp++;
                if (b_rank_sym !== 4'(es) || b_rank_cnt !== 4'(ec) || b_rank_last !== (got == 9)) begin
                    n_err++;
                    $display("FAIL n10_rank%0d: (%0d,%0d,last=%b) required (%0d,%0d,last=%b)",
                             got, b_rank_sym, b_rank_cnt, b_rank_last, es, ec, got == 9);
                end
                got++;
            end
        end
        @(negedge clk);
        b_rank_ready = 1'b0;
        n_cmp++;
        if (got != 10 || b_rank_valid !== 1'b0 || b_busy !== 1'b0) begin
            n_err++;
            $display("FAIL n10_end: got=%0d rank_valid=%b busy=%b required 10,0,0", got, b_rank_valid, b_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_saturate();
        test_back_to_back();
        test_all_ignored();
        test_reset_abort();
        test_nsym10();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
